// File: rtl/cdc_4phase_src_arb.sv
// -----------------------------------------------------------------------------
// cdc_4phase_src_arb
//
// Source half of a 4-phase (return-to-zero) clock-domain-crossing link that
// serves NumChannels upstream valid/ready ports over a single async link.
// A round-robin arbiter picks one valid channel while the link is idle, the
// payload and its channel index are captured into output registers, and the
// request is held until the (synchronised) acknowledge completes the full
// req-up / ack-up / req-down / ack-down sequence.
//
// Ports
//   clk_i         clock (single domain)
//   rst_ni        asynchronous active-low reset
//   data_i        per-channel payload, channel i at [i*DataWidth +: DataWidth]
//   valid_i       per-channel valid
//   ready_o       per-channel ready, one-hot or zero
//   async_req_o   registered 4-phase request
//   async_ack_i   4-phase acknowledge from the destination, unsynchronised
//   async_data_o  registered payload, stable while the handshake is in flight
//   async_chan_o  registered channel index belonging to async_data_o
//   busy_o        high whenever the FSM is not IDLE
//   timeout_o     high while the current handshake phase has stalled for
//                 TimeoutCycles cycles (observational only)
// -----------------------------------------------------------------------------
module cdc_4phase_src_arb #(
  parameter int                   NumChannels   = 2,
  parameter int                   DataWidth     = 32,
  parameter int                   SyncStages    = 2,
  parameter int                   Decoupled     = 1,
  parameter int                   TimeoutCycles = 0,
  parameter int                   SendResetMsg  = 0,
  parameter logic [DataWidth-1:0] ResetMsg      = '0,
  localparam int                  IdxWidth      = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumChannels*DataWidth-1:0] data_i,
  input  logic [NumChannels-1:0]           valid_i,
  output logic [NumChannels-1:0]           ready_o,
  output logic                             async_req_o,
  input  logic                             async_ack_i,
  output logic [DataWidth-1:0]             async_data_o,
  output logic [IdxWidth-1:0]              async_chan_o,
  output logic                             busy_o,
  output logic                             timeout_o
);

  typedef enum logic [1:0] {
    IDLE              = 2'd0,
    WAIT_ACK_ASSERT   = 2'd1,
    WAIT_ACK_DEASSERT = 2'd2
  } state_e;

  // With a reset message the link comes out of reset already requesting.
  localparam state_e            ResetState = (SendResetMsg != 0) ? WAIT_ACK_ASSERT : IDLE;
  localparam logic [IdxWidth:0] NumChanExt = (IdxWidth + 1)'(NumChannels);
  localparam logic [IdxWidth-1:0] LastChan = IdxWidth'(NumChannels - 1);

  state_e                 r_state;
  state_e                 w_state_next;
  logic [SyncStages-1:0]  r_ack_sync;
  logic                   w_ack_s;
  logic                   r_req;
  logic                   w_req_next;
  logic [DataWidth-1:0]   r_data;
  logic [DataWidth-1:0]   w_data_next;
  logic [IdxWidth-1:0]    r_chan;
  logic [IdxWidth-1:0]    w_chan_next;
  logic [IdxWidth-1:0]    r_rr;
  logic [IdxWidth-1:0]    w_rr_next;
  logic                   w_gnt_vld;
  logic [IdxWidth-1:0]    w_gnt_idx;
  logic [IdxWidth:0]      w_scan;
  logic                   w_ready_en;
  logic [IdxWidth-1:0]    w_ready_idx;
  logic [NumChannels-1:0] w_ready_vec;

  // ---------------------------------------------------------------------------
  // Acknowledge synchroniser
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[SyncStages-2:0], async_ack_i};
    end
  end

  assign w_ack_s = r_ack_sync[SyncStages-1];

  // ---------------------------------------------------------------------------
  // Round-robin arbiter. Channels are visited in the order rr, rr+1, ... mod N.
  // The loop runs from the farthest offset back to offset 0 so that the last
  // hit (the nearest channel to rr) wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_scan    = '0;
    for (int i = NumChannels - 1; i >= 0; i--) begin
      w_scan = {1'b0, r_rr} + (IdxWidth + 1)'(i);
      if (w_scan >= NumChanExt) begin
        w_scan = w_scan - NumChanExt;
      end
      if (valid_i[w_scan[IdxWidth-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_scan[IdxWidth-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ResetState;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_req_next   = r_req;
    w_data_next  = r_data;
    w_chan_next  = r_chan;
    w_rr_next    = r_rr;
    w_ready_en   = 1'b0;
    w_ready_idx  = '0;
    case (r_state)
      IDLE: begin
        w_req_next = 1'b0;
        if (w_gnt_vld) begin
          w_state_next = WAIT_ACK_ASSERT;
          w_req_next   = 1'b1;
          w_data_next  = data_i[w_gnt_idx*DataWidth +: DataWidth];
          w_chan_next  = w_gnt_idx;
          w_rr_next    = (w_gnt_idx == LastChan) ? '0 : w_gnt_idx + IdxWidth'(1);
          if (Decoupled != 0) begin
            w_ready_en  = 1'b1;
            w_ready_idx = w_gnt_idx;
          end
        end
      end
      WAIT_ACK_ASSERT: begin
        w_req_next = 1'b1;
        if (w_ack_s) begin
          w_req_next   = 1'b0;
          w_state_next = WAIT_ACK_DEASSERT;
        end
      end
      WAIT_ACK_DEASSERT: begin
        w_req_next = 1'b0;
        if (!w_ack_s) begin
          w_state_next = IDLE;
          // Coupled mode: the upstream item is only released once the whole
          // handshake has completed.
          if (Decoupled == 0) begin
            w_ready_en  = 1'b1;
            w_ready_idx = r_chan;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_req_next   = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Link output registers and round-robin pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req  <= (SendResetMsg != 0);
      r_data <= (SendResetMsg != 0) ? ResetMsg : '0;
      r_chan <= '0;
      r_rr   <= '0;
    end else begin
      r_req  <= w_req_next;
      r_data <= w_data_next;
      r_chan <= w_chan_next;
      r_rr   <= w_rr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Ready decode. Ready is forced low while reset is asserted because in
  // decoupled mode it would otherwise follow valid_i combinationally.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NumChannels; gi++) begin : g_ready
    assign w_ready_vec[gi] = w_ready_en && (w_ready_idx == IdxWidth'(gi));
  end

  assign ready_o = rst_ni ? w_ready_vec : '0;

  // ---------------------------------------------------------------------------
  // Stall timeout: counts cycles spent in the current WAIT_* state, clears on
  // every state change and saturates at TimeoutCycles.
  // ---------------------------------------------------------------------------
  if (TimeoutCycles > 0) begin : g_timeout
    localparam int CntWidth = $clog2(TimeoutCycles + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(TimeoutCycles);

    logic [CntWidth-1:0] r_tmo_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_tmo_cnt <= '0;
      end else if ((w_state_next != r_state) || (r_state == IDLE)) begin
        r_tmo_cnt <= '0;
      end else if (r_tmo_cnt != CntMax) begin
        r_tmo_cnt <= r_tmo_cnt + CntWidth'(1);
      end
    end

    assign timeout_o = (r_tmo_cnt == CntMax);
  end else begin : g_no_timeout
    assign timeout_o = 1'b0;
  end

  assign async_req_o  = r_req;
  assign async_data_o = r_data;
  assign async_chan_o = r_chan;
  assign busy_o       = (r_state != IDLE);

endmodule
